lvt_read_mux: RTL
=================

# lvt_read_mux

Read-side companion to the live-value-table (LVT) write tracker in the multi-ported memory. It keeps a per-address record of which write port's BRAM bank holds the most recent value and, for each read port, looks up that bank at read issue. It then selects the matching bank output one cycle later and presents registered read data. It sits between the replicated BRAM banks (one bank per write port per read port) and the memory's read ports.

## Interface

- `index_width`, 8, address width; the table has 2**index_width entries.
- `data_width`, 32, data word width.
- `n_wr`, 2, number of write ports, which is also the number of banks per read port.
- `n_rd`, 2, number of read ports.
- `n_bits_bank`, 1, bank-index width; must satisfy 2**n_bits_bank >= n_wr.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_addr`  in  n_wr*index_width  write address; port i occupies slice [i*index_width +: index_width].
- `wr_en`  in  n_wr  write enable per write port.
- `wr_data`  in  n_wr*data_width  write data per port; used only with the bypass feature.
- `rd_addr`  in  n_rd*index_width  read address per read port.
- `rd_en`  in  n_rd  read request per read port.
- `bank_rdata`  in  n_rd*n_wr*data_width  bank outputs; read port r, bank w at slice [(r*n_wr+w)*data_width +: data_width]; 1-cycle BRAM latency.
- `rd_data`  out  n_rd*data_width  registered read data.
- `rd_valid`  out  n_rd  rd_data valid, one pulse per accepted read.
- `rd_bank`  out  n_rd*n_bits_bank  registered bank index used for the most recent read; debug and verification aid.

## Operation

- Table: lvt[2**index_width], each entry n_bits_bank wide. On reset, every entry 0 through 2**index_width-1 is set to 0, i.e. bank 0.
- Write update:
  - On each edge, for every i with wr_en[i]=1: lvt[wr_addr_i] <= i.
  - If several write ports hit the same address in the same cycle, the highest port index wins.
- Read stage 1 (edge E0, rd_en[r]=1):
  - sel_r <= lvt[rd_addr_r], the table value before E0's writes.
  - The pipeline valid bit v1_r <= 1.
  - rd_bank_r is updated with the same value.
- Read stage 2 (edge E1):
  - If v1_r=1: rd_data_r <= bank_rdata[r][sel_r] and rd_valid[r] <= 1.
  - Otherwise rd_valid[r] <= 0 and rd_data_r holds its previous value.
- Read ports are fully independent and may all issue every cycle; full throughput, no stalls, no backpressure.
- Reset asserted mid-operation:
  - All in-flight reads are discarded.
  - Table returns to all-zero.
  - Outputs go to their reset values immediately (asynchronous).
- Reset values: rd_data=0, rd_valid=0, rd_bank=0, all pipeline valid bits 0.

## Timing

- Latency: rd_en at edge E0 gives rd_valid/rd_data after edge E1, i.e. 2 edges from request to data.
- rd_bank is visible after E0, one cycle ahead of the data.
- Write-to-table latency is 1 edge. A read issued on the edge after a write sees the new bank.
- A read and a write to the same address on the same edge: see Configuration.
- An address outside the written set returns bank 0 data.

## Configuration

- Macro: `LVT_WR_BYPASS_EN`.
- Defined:
  - A same-edge read/write address match on read port r captures the write port index into sel_r and captures that port's wr_data into a bypass register.
  - At stage 2, rd_data_r comes from the bypass register, not from bank_rdata. The read returns new data whatever the BRAM's read-during-write mode.
  - With multiple matching writers, the highest index wins.
- Undefined:
  - The same-edge read uses the pre-write table value and bank_rdata (old-bank semantics).
  - wr_data is ignored, and no bypass registers exist.

## Test plan

- Reset, then read address 0x05 on both ports with bank_rdata bank0=0xA0, bank1=0xB1 -> after 2 edges, rd_valid=2'b11, rd_data=0xA0 on both ports, rd_bank=0.
- Write port 1 at 0x10, then next cycle read 0x10 on port 0 -> rd_bank=1, rd_data=bank1 value, rd_valid pulses exactly 1 cycle.
- Ports 0 and 1 write 0x20 on the same edge, then read 0x20 -> bank 1 selected.
- Read and write port 1 to 0x30 on the same edge with wr_data=0xDEAD:
  - Bypass defined: rd_data=0xDEAD.
  - Bypass undefined: rd_data = bank0 output, rd_bank=0.
- Back-to-back reads every cycle on both ports to addresses 0..15 with alternating prior writers -> 16 consecutive rd_valid pulses, each with the correct bank data.
- Assert reset between stage 1 and stage 2 of a read -> rd_valid stays 0, and a subsequent read of a previously written address returns bank 0.

Source files
------------

// File: rtl/lvt_read_mux_if.sv
// lvt_read_mux_if: write, read-request, bank-data and read-result bundle for lvt_read_mux
// master: the memory side that drives writes, reads and bank outputs; slave: lvt_read_mux itself.
// Ports: wr_addr/wr_en/wr_data are the write ports, rd_addr/rd_en are the read requests,
//   bank_rdata carries the replicated bank outputs, and rd_data/rd_valid/rd_bank are the read results.
interface lvt_read_mux_if #(
  parameter int index_width = 8,
  parameter int data_width  = 32,
  parameter int n_wr        = 2,
  parameter int n_rd        = 2,
  parameter int n_bits_bank = 1
);
  logic [n_wr*index_width-1:0]     wr_addr;
  logic [n_wr-1:0]                 wr_en;
  logic [n_wr*data_width-1:0]      wr_data;
  logic [n_rd*index_width-1:0]     rd_addr;
  logic [n_rd-1:0]                 rd_en;
  logic [n_rd*n_wr*data_width-1:0] bank_rdata;
  logic [n_rd*data_width-1:0]      rd_data;
  logic [n_rd-1:0]                 rd_valid;
  logic [n_rd*n_bits_bank-1:0]     rd_bank;
  modport master (
    output wr_addr, wr_en, wr_data, rd_addr, rd_en, bank_rdata,
    input  rd_data, rd_valid, rd_bank
  );
  modport slave (
    input  wr_addr, wr_en, wr_data, rd_addr, rd_en, bank_rdata,
    output rd_data, rd_valid, rd_bank
  );
endinterface

// File: rtl/lvt_read_mux.sv
// lvt_read_mux: live-value-table read side; tracks the newest writer per address and muxes that writer's bank onto each read port
// Ports: clk (rising edge), reset (asynchronous, active-low), bus (slave modport of lvt_read_mux_if).
//   Inputs on bus: wr_addr, wr_en and wr_data for the write ports; rd_addr and rd_en for the read requests;
//   bank_rdata for the bank outputs, which have a 1-cycle latency.
//   Outputs on bus: rd_data and rd_valid give the registered read result; rd_bank gives the bank chosen at read issue.
// Optional feature, enabled by defining LVT_WR_BYPASS_EN: a write landing on a read address on the same edge
//   forwards that write's wr_data to the read instead of the stale bank output.
module lvt_read_mux #(
  parameter int index_width = 8,
  parameter int data_width  = 32,
  parameter int n_wr        = 2,
  parameter int n_rd        = 2,
  parameter int n_bits_bank = 1
) (
  input logic clk,
  input logic reset,
  lvt_read_mux_if.slave bus
);
  localparam int depth = 2 ** index_width;
  logic [n_bits_bank-1:0] lvt  [depth];
  logic [n_bits_bank-1:0] look [n_rd];
  logic [n_bits_bank-1:0] sel  [n_rd];
  logic [data_width-1:0]  pick [n_rd];
  logic [n_rd-1:0]        v1;
  // Ascending port order makes the highest-index writer's assignment the last one, so it wins on address collisions.
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int a = 0; a < depth; a++) lvt[a] <= '0;
    else for (int i = 0; i < n_wr; i++)
      if (bus.wr_en[i]) lvt[bus.wr_addr[i*index_width +: index_width]] <= n_bits_bank'(i);
`ifdef LVT_WR_BYPASS_EN
  logic [n_rd-1:0]       hit;
  logic [n_rd-1:0]       byp_sel;
  logic [data_width-1:0] byp_d [n_rd];
  logic [data_width-1:0] byp_q [n_rd];
  always_comb
    for (int r = 0; r < n_rd; r++) begin
      look[r]  = lvt[bus.rd_addr[r*index_width +: index_width]];
      hit[r]   = 1'b0;
      byp_d[r] = '0;
      for (int i = 0; i < n_wr; i++)
        if (bus.wr_en[i] && bus.wr_addr[i*index_width +: index_width] == bus.rd_addr[r*index_width +: index_width]) begin
          look[r]  = n_bits_bank'(i);
          hit[r]   = 1'b1;
          byp_d[r] = bus.wr_data[i*data_width +: data_width];
        end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      byp_sel <= '0;
      for (int r = 0; r < n_rd; r++) byp_q[r] <= '0;
    end else for (int r = 0; r < n_rd; r++)
      if (bus.rd_en[r]) begin
        byp_sel[r] <= hit[r];
        byp_q[r]   <= byp_d[r];
      end
  always_comb
    for (int r = 0; r < n_rd; r++)
      pick[r] = byp_sel[r] ? byp_q[r] : bus.bank_rdata[(r*n_wr + int'(sel[r]))*data_width +: data_width];
`else
  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data;
  always_comb
    for (int r = 0; r < n_rd; r++) begin
      look[r] = lvt[bus.rd_addr[r*index_width +: index_width]];
      pick[r] = bus.bank_rdata[(r*n_wr + int'(sel[r]))*data_width +: data_width];
    end
`endif
  // Stage 1 captures the bank choice while the banks read; stage 2 muxes the chosen bank once its data arrives.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v1           <= '0;
      bus.rd_valid <= '0;
      bus.rd_data  <= '0;
      bus.rd_bank  <= '0;
      for (int r = 0; r < n_rd; r++) sel[r] <= '0;
    end else begin
      v1           <= bus.rd_en;
      bus.rd_valid <= v1;
      for (int r = 0; r < n_rd; r++) begin
        if (bus.rd_en[r]) begin
          sel[r]                                  <= look[r];
          bus.rd_bank[r*n_bits_bank +: n_bits_bank] <= look[r];
        end
        if (v1[r]) bus.rd_data[r*data_width +: data_width] <= pick[r];
      end
    end
endmodule
